// File: rtl/uart_rx_ext_if.sv
// Receive-side output bundle of uart_rx_ext: received word, qualifying
// flags and status pulses toward the RX FIFO / register block.
interface uart_rx_ext_if #(
  parameter int MAX_DATA_BITS = 9
) ();
  logic [MAX_DATA_BITS-1:0] data_out;
  logic                     data_valid;
  logic                     parity_err;
  logic                     frame_err;
  logic                     break_det;
  logic                     timeout;
  logic                     busy;

  modport master (
    output data_out, data_valid, parity_err, frame_err, break_det, timeout, busy
  );

  modport slave (
    input data_out, data_valid, parity_err, frame_err, break_det, timeout, busy
  );
endinterface

// File: rtl/uart_rx_ext.sv
// Configurable UART receiver: 5..MAX_DATA_BITS data bits, none/even/odd
// parity, 1 or 2 stop bits, majority-of-3 bit decisions, false-start
// rejection, break detection and an idle-timeout pulse.
module uart_rx_ext #(
  parameter int MAX_DATA_BITS = 9,
  parameter int OVERSAMPLE    = 16,
  parameter int TIMEOUT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 os_tick,
  input  logic                 rx,
  input  logic [3:0]           cfg_data_bits,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  uart_rx_ext_if.master        bus
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int MID    = OVERSAMPLE / 2;

  localparam logic [TICK_W-1:0] T_S0   = TICK_W'(MID - 1);
  localparam logic [TICK_W-1:0] T_S1   = TICK_W'(MID);
  localparam logic [TICK_W-1:0] T_DEC  = TICK_W'(MID + 1);
  localparam logic [TICK_W-1:0] T_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [3:0]        MAXB   = 4'(MAX_DATA_BITS);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_DATA     = 3'd2;
  localparam logic [2:0] S_PARITY   = 3'd3;
  localparam logic [2:0] S_STOP1    = 3'd4;
  localparam logic [2:0] S_STOP2    = 3'd5;
  localparam logic [2:0] S_BRK_WAIT = 3'd6;

  logic                     rx_meta, rxs, rxs_prev;
  logic [2:0]               state;
  logic [TICK_W-1:0]        tick_cnt;
  logic [3:0]               bit_cnt;
  logic [3:0]               f_bits;
  logic [1:0]               f_par;
  logic                     f_stop2;
  logic [MAX_DATA_BITS-1:0] shreg;
  logic                     par_acc, any_one;
  logic                     s_a, s_b;
  logic                     perr_p, ferr_p;
  logic [MAX_DATA_BITS-1:0] data_out_r;
  logic                     dv_r, perr_r, ferr_r, brk_r, to_r;
  logic                     armed;
  logic [TICK_W-1:0]        to_tick;
  logic [TIMEOUT_W-1:0]     to_bits;

  logic       maj, start_edge, tick_last, at_dec, par_on;
  logic [3:0] bits_clamp;

  assign maj        = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);
  assign start_edge = rxs_prev & ~rxs;
  assign tick_last  = (tick_cnt == T_LAST);
  assign at_dec     = (tick_cnt == T_DEC);
  assign par_on     = (f_par == 2'b01) || (f_par == 2'b10);

  // Clamp the requested data width into the supported range.
  always_comb begin
    bits_clamp = cfg_data_bits;
    if (cfg_data_bits < 4'd5)
      bits_clamp = 4'd5;
    else if (cfg_data_bits > MAXB)
      bits_clamp = MAXB;
  end

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  // Frame FSM: bit timing, majority sampling, shifting and end-of-frame pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      f_bits     <= 4'd8;
      f_par      <= '0;
      f_stop2    <= 1'b0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      any_one    <= 1'b0;
      s_a        <= 1'b0;
      s_b        <= 1'b0;
      perr_p     <= 1'b0;
      ferr_p     <= 1'b0;
      data_out_r <= '0;
      dv_r       <= 1'b0;
      perr_r     <= 1'b0;
      ferr_r     <= 1'b0;
      brk_r      <= 1'b0;
    end else begin
      dv_r  <= 1'b0;
      brk_r <= 1'b0;
      if (!enable) begin
        state    <= S_IDLE;
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            // A tick coinciding with the edge is deliberately not counted.
            if (start_edge) begin
              state    <= S_START;
              tick_cnt <= '0;
              bit_cnt  <= '0;
              f_bits   <= bits_clamp;
              f_par    <= cfg_parity;
              f_stop2  <= cfg_stop2;
              shreg    <= '0;
              par_acc  <= 1'b0;
              any_one  <= 1'b0;
              perr_p   <= 1'b0;
              ferr_p   <= 1'b0;
            end
          end
          S_BRK_WAIT: begin
            if (rxs)
              state <= S_IDLE;
          end
          default: begin
            if (os_tick) begin
              tick_cnt <= tick_last ? '0 : tick_cnt + 1'b1;
              if (tick_cnt == T_S0) s_a <= rxs;
              if (tick_cnt == T_S1) s_b <= rxs;
              // End-of-bit transitions come first so that a decision landing
              // on the same tick (small OVERSAMPLE) can override them.
              case (state)
                S_START: begin
                  if (tick_last) state <= S_DATA;
                  if (at_dec && maj) begin
                    state    <= S_IDLE;
                    tick_cnt <= '0;
                  end
                end
                S_DATA: begin
                  if (at_dec) begin
                    shreg[bit_cnt] <= maj;
                    par_acc        <= par_acc ^ maj;
                    any_one        <= any_one | maj;
                  end
                  if (tick_last) begin
                    if (bit_cnt == f_bits - 4'd1) begin
                      bit_cnt <= '0;
                      state   <= par_on ? S_PARITY : S_STOP1;
                    end else begin
                      bit_cnt <= bit_cnt + 4'd1;
                    end
                  end
                end
                S_PARITY: begin
                  if (at_dec) begin
                    any_one <= any_one | maj;
                    if (f_par == 2'b01)
                      perr_p <= par_acc ^ maj;
                    else
                      perr_p <= ~(par_acc ^ maj);
                  end
                  if (tick_last) state <= S_STOP1;
                end
                S_STOP1: begin
                  if (tick_last) state <= S_STOP2;
                  if (at_dec) begin
                    if (!maj && !any_one) begin
                      brk_r    <= 1'b1;
                      state    <= S_BRK_WAIT;
                      tick_cnt <= '0;
                    end else if (f_stop2) begin
                      ferr_p <= ferr_p | ~maj;
                    end else begin
                      dv_r       <= 1'b1;
                      data_out_r <= shreg;
                      perr_r     <= perr_p;
                      ferr_r     <= ferr_p | ~maj;
                      state      <= S_IDLE;
                      tick_cnt   <= '0;
                    end
                  end
                end
                S_STOP2: begin
                  if (at_dec) begin
                    dv_r       <= 1'b1;
                    data_out_r <= shreg;
                    perr_r     <= perr_p;
                    ferr_r     <= ferr_p | ~maj;
                    state      <= S_IDLE;
                    tick_cnt   <= '0;
                  end
                end
                default: begin
                  state    <= S_IDLE;
                  tick_cnt <= '0;
                end
              endcase
            end
          end
        endcase
      end
    end
  end

  // Idle timeout: armed by each frame/break pulse, counts whole bit times in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      to_tick <= '0;
      to_bits <= '0;
      to_r    <= 1'b0;
    end else begin
      to_r <= 1'b0;
      if (!enable) begin
        armed   <= 1'b0;
        to_tick <= '0;
        to_bits <= '0;
      end else if (dv_r || brk_r) begin
        armed   <= 1'b1;
        to_tick <= '0;
        to_bits <= '0;
      end else if (state == S_IDLE && start_edge) begin
        to_tick <= '0;
        to_bits <= '0;
      end else if (armed && state == S_IDLE && os_tick) begin
        if (to_tick == T_LAST) begin
          to_tick <= '0;
          if (cfg_timeout != '0 && to_bits + 1'b1 == cfg_timeout) begin
            to_r    <= 1'b1;
            armed   <= 1'b0;
            to_bits <= '0;
          end else begin
            to_bits <= to_bits + 1'b1;
          end
        end else begin
          to_tick <= to_tick + 1'b1;
        end
      end
    end
  end

  assign bus.data_out   = data_out_r;
  assign bus.data_valid = dv_r;
  assign bus.parity_err = perr_r;
  assign bus.frame_err  = ferr_r;
  assign bus.break_det  = brk_r;
  assign bus.timeout    = to_r;
  assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: table of frame vectors plus hand-written
// sequences for false start, break, idle timeout and enable drop.
module tb_uart_rx_ext;
  localparam int MAXB = 9;
  localparam int OS   = 16;
  localparam int TW   = 8;
  localparam int TDIV = 4;
  localparam int BITC = OS * TDIV;

  logic          clk = 1'b0;
  logic          rst_n, enable, os_tick, rx;
  logic [3:0]    cfg_data_bits;
  logic [1:0]    cfg_parity;
  logic          cfg_stop2;
  logic [TW-1:0] cfg_timeout;

  uart_rx_ext_if #(.MAX_DATA_BITS(MAXB)) bus ();

  uart_rx_ext #(.MAX_DATA_BITS(MAXB), .OVERSAMPLE(OS), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .os_tick(os_tick), .rx(rx),
    .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .cfg_timeout(cfg_timeout), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Oversample strobe: one clock high every TDIV clocks.
  initial begin
    int div;
    div = 0;
    os_tick = 1'b0;
    forever begin
      @(negedge clk);
      os_tick = (div == TDIV - 1);
      div = (div + 1) % TDIV;
    end
  end

  // Pulse monitor, sampled on the falling edge.
  int cyc = 0, dv_cnt = 0, brk_cnt = 0, to_cnt = 0;
  int last_dv_cyc = 0, last_to_cyc = 0;
  logic [8:0] last_data = '0;
  logic       last_perr = 1'b0, last_ferr = 1'b0;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.data_valid === 1'b1) begin
      dv_cnt = dv_cnt + 1;
      last_dv_cyc = cyc;
      last_data = bus.data_out;
      last_perr = bus.parity_err;
      last_ferr = bus.frame_err;
    end
    if (bus.break_det === 1'b1) brk_cnt = brk_cnt + 1;
    if (bus.timeout === 1'b1) begin
      to_cnt = to_cnt + 1;
      last_to_cyc = cyc;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BITC) @(negedge clk);
  endtask

  // spar: 0 none, 1 even, 2 odd; sbad bit0/bit1 force stop1/stop2 low.
  task automatic send_frame(input int nbits, input logic [8:0] data, input int spar,
                            input bit pflip, input bit stop2, input int sbad);
    logic p;
    p = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) begin
      send_bit(data[i]);
      p = p ^ data[i];
    end
    if (spar == 1) send_bit(p ^ pflip);
    if (spar == 2) send_bit(~p ^ pflip);
    send_bit(sbad[0] ? 1'b0 : 1'b1);
    if (stop2) send_bit(sbad[1] ? 1'b0 : 1'b1);
    rx = 1'b1;
  endtask

  typedef struct {
    int         cfg_bits;
    int         cfg_par;
    int         nbits;
    logic [8:0] data;
    int         spar;
    bit         pflip;
    bit         stop2;
    int         sbad;
    logic [8:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;

  vec_t vt[9];

  initial begin
    int d0, b0, t0;
    vt[0] = '{8,  0, 8, 9'h0A5, 0, 1'b0, 1'b0, 0, 9'h0A5, 1'b0, 1'b0}; // 8N1
    vt[1] = '{7,  1, 7, 9'h035, 1, 1'b1, 1'b1, 0, 9'h035, 1'b1, 1'b0}; // 7E2 bad parity
    vt[2] = '{7,  1, 7, 9'h035, 1, 1'b0, 1'b1, 0, 9'h035, 1'b0, 1'b0}; // 7E2 good
    vt[3] = '{9,  2, 9, 9'h1FF, 2, 1'b0, 1'b0, 0, 9'h1FF, 1'b0, 1'b0}; // 9O1
    vt[4] = '{8,  0, 8, 9'h03C, 0, 1'b0, 1'b0, 1, 9'h03C, 1'b0, 1'b1}; // stop1 low
    vt[5] = '{3,  0, 5, 9'h015, 0, 1'b0, 1'b0, 0, 9'h015, 1'b0, 1'b0}; // clamp to 5
    vt[6] = '{7,  2, 7, 9'h02A, 2, 1'b1, 1'b1, 2, 9'h02A, 1'b1, 1'b1}; // 7O2 both errs
    vt[7] = '{15, 0, 9, 9'h1AB, 0, 1'b0, 1'b0, 0, 9'h1AB, 1'b0, 1'b0}; // clamp to 9
    vt[8] = '{8,  3, 8, 9'h081, 0, 1'b0, 1'b0, 0, 9'h081, 1'b0, 1'b0}; // parity 11 = none

    rst_n = 1'b0; enable = 1'b0; rx = 1'b1;
    cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0; cfg_timeout = '0;
    repeat (5) @(negedge clk);
    check("rst_data_out",   32'(bus.data_out),   32'h0);
    check("rst_data_valid", 32'(bus.data_valid), 32'h0);
    check("rst_parity_err", 32'(bus.parity_err), 32'h0);
    check("rst_frame_err",  32'(bus.frame_err),  32'h0);
    check("rst_break_det",  32'(bus.break_det),  32'h0);
    check("rst_timeout",    32'(bus.timeout),    32'h0);
    check("rst_busy",       32'(bus.busy),       32'h0);
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (BITC) @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      cfg_data_bits = 4'(vt[v].cfg_bits);
      cfg_parity    = 2'(vt[v].cfg_par);
      cfg_stop2     = vt[v].stop2;
      d0 = dv_cnt; b0 = brk_cnt;
      send_frame(vt[v].nbits, vt[v].data, vt[v].spar, vt[v].pflip, vt[v].stop2, vt[v].sbad);
      check($sformatf("v%0d_valid_cnt", v), 32'(dv_cnt - d0), 32'd1);
      check($sformatf("v%0d_break_cnt", v), 32'(brk_cnt - b0), 32'd0);
      check($sformatf("v%0d_data", v), 32'(last_data), 32'(vt[v].exp_data));
      check($sformatf("v%0d_perr", v), 32'(last_perr), 32'(vt[v].exp_perr));
      check($sformatf("v%0d_ferr", v), 32'(last_ferr), 32'(vt[v].exp_ferr));
      check($sformatf("v%0d_busy", v), 32'(bus.busy), 32'h0);
      repeat (BITC / 2) @(negedge clk);
    end

    // False start: 4 ticks low.
    cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    d0 = dv_cnt; b0 = brk_cnt;
    rx = 1'b0;
    repeat (8) @(negedge clk);
    check("fs_busy_start", 32'(bus.busy), 32'h1);
    repeat (4 * TDIV - 8) @(negedge clk);
    rx = 1'b1;
    repeat (BITC) @(negedge clk);
    check("fs_busy_after", 32'(bus.busy), 32'h0);
    check("fs_valid_cnt", 32'(dv_cnt - d0), 32'd0);
    check("fs_break_cnt", 32'(brk_cnt - b0), 32'd0);

    // Break: 20 bit times low.
    d0 = dv_cnt; b0 = brk_cnt;
    rx = 1'b0;
    repeat (20 * BITC) @(negedge clk);
    check("brk_cnt", 32'(brk_cnt - b0), 32'd1);
    check("brk_valid_cnt", 32'(dv_cnt - d0), 32'd0);
    check("brk_busy_low_line", 32'(bus.busy), 32'h1);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check("brk_busy_released", 32'(bus.busy), 32'h0);
    repeat (BITC) @(negedge clk);
    d0 = dv_cnt;
    send_frame(8, 9'h055, 0, 1'b0, 1'b0, 0);
    check("brk_next_valid", 32'(dv_cnt - d0), 32'd1);
    check("brk_next_data", 32'(last_data), 32'h055);
    check("brk_next_errs", 32'({last_perr, last_ferr}), 32'h0);

    // Idle timeout of 3 bit times.
    repeat (BITC) @(negedge clk);
    cfg_timeout = 8'd3;
    t0 = to_cnt;
    send_frame(8, 9'h012, 0, 1'b0, 1'b0, 0);
    repeat (6 * BITC) @(negedge clk);
    check("to_once", 32'(to_cnt - t0), 32'd1);
    check("to_delay", 32'(last_to_cyc - last_dv_cyc), 32'(3 * BITC));
    check("to_data", 32'(last_data), 32'h012);
    t0 = to_cnt;
    send_frame(8, 9'h012, 0, 1'b0, 1'b0, 0);
    repeat (BITC) @(negedge clk);
    send_frame(8, 9'h034, 0, 1'b0, 1'b0, 0);
    check("to_suppressed", 32'(to_cnt - t0), 32'd0);
    check("to_second_data", 32'(last_data), 32'h034);
    cfg_timeout = '0;
    repeat (6 * BITC) @(negedge clk);
    check("to_zero_disabled", 32'(to_cnt - t0), 32'd0);

    // 9-bit odd parity, then enable drop mid-frame.
    cfg_data_bits = 4'd9; cfg_parity = 2'b10; cfg_stop2 = 1'b0;
    d0 = dv_cnt;
    send_frame(9, 9'h1FF, 2, 1'b0, 1'b0, 0);
    check("en_first_valid", 32'(dv_cnt - d0), 32'd1);
    check("en_first_data", 32'(last_data), 32'h1FF);
    d0 = dv_cnt; b0 = brk_cnt; t0 = to_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    enable = 1'b0;
    @(negedge clk);
    check("en_drop_busy", 32'(bus.busy), 32'h0);
    check("en_drop_data_held", 32'(bus.data_out), 32'h1FF);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    enable = 1'b1;
    repeat (2 * BITC) @(negedge clk);
    check("en_drop_no_valid", 32'(dv_cnt - d0), 32'd0);
    check("en_drop_no_pulses", 32'((brk_cnt - b0) + (to_cnt - t0)), 32'd0);
    send_frame(9, 9'h100, 2, 1'b0, 1'b0, 0);
    check("en_re_valid", 32'(dv_cnt - d0), 32'd1);
    check("en_re_data", 32'(last_data), 32'h100);
    check("en_re_errs", 32'({last_perr, last_ferr}), 32'h0);

    repeat (BITC) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_ext.md
Name: uart_rx_ext

Overview:
- Configurable UART receiver, next generation after the fixed 8N1 RX.
- Runtime-selectable data width (5..MAX_DATA_BITS), parity (none/even/odd) and 1 or 2 stop bits.
- Majority-of-3 oversampled bit decisions, false-start rejection, break detection and an RX idle-timeout pulse.
- Sits between the oversample tick generator and the RX FIFO / register block of the UART top.

Parameters:
- MAX_DATA_BITS, 9, widest supported data field; legal range 5..9.
- OVERSAMPLE, 16, os_tick pulses per bit time; even, >= 4.
- TIMEOUT_W, 8, width of cfg_timeout in bit times.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  receiver enable; low forces IDLE synchronously.
- os_tick  in  1  single-cycle oversample strobe.
- rx  in  1  asynchronous serial input.
- cfg_data_bits  in  4  data bits per frame; clamped to 5..MAX_DATA_BITS.
- cfg_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- cfg_stop2  in  1  1 = two stop bits checked.
- cfg_timeout  in  TIMEOUT_W  idle bit-times before timeout pulse; 0 disables.
- data_out  out  MAX_DATA_BITS  last received word, LSB = first bit, upper unused bits 0.
- data_valid  out  1  one-cycle pulse, data_out and error flags valid.
- parity_err  out  1  qualifies data_valid.
- frame_err  out  1  qualifies data_valid.
- break_det  out  1  one-cycle pulse on break frame.
- timeout  out  1  one-cycle idle-timeout pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0. Synchroniser flops reset to 1. State is IDLE. Counters are 0. Timeout is disarmed.
- rx passes through a 2-flop synchroniser. All decisions use the synchronised value rxs.
- Ticks: tick_cnt counts os_tick events within a bit, 0..OVERSAMPLE-1. MID = OVERSAMPLE/2.
- Samples are taken at tick_cnt MID-1, MID and MID+1. The bit value is the majority of the three. The decision is made at the MID+1 tick.
- IDLE -> START: on an rxs 1->0 edge while enable is high. At that point cfg_* are latched into frame registers; later cfg changes do not affect the frame. tick_cnt is cleared.
- START: if the majority bit is 1, this is a false start; return to IDLE with no outputs. Otherwise go to DATA after OVERSAMPLE ticks from the edge.
- DATA: shift the decided bit in LSB-first. bit_cnt counts to the latched data_bits. Then go to PARITY if parity is enabled, else STOP1.
- PARITY: even parity requires the XOR of data and parity bit to be 0; odd requires 1. A mismatch sets the pending parity_err.
- STOP1, then STOP2 if cfg_stop2: any stop bit decided 0 sets the pending frame_err.
- End of frame: in the cycle after the last stop-bit decision, drive data_valid=1 with parity_err and frame_err for one cycle. data_out holds until the next valid.
- Return to IDLE immediately after the final stop decision, with no wait for the rest of the bit. This allows back-to-back frames.
- Break: data bits all 0, parity bit 0 (if present) and STOP1 decided 0. Pulse break_det instead of data_valid, then enter BRK_WAIT.
- BRK_WAIT: stay until rxs=1, then go to IDLE. No new start is detected while in BRK_WAIT.
- Timeout:
  - Arms on each data_valid or break_det.
  - While armed and in IDLE, count completed bit times (OVERSAMPLE ticks).
  - On reaching cfg_timeout, pulse timeout for one cycle and disarm.
  - A new start edge clears the count.
  - cfg_timeout=0 never fires.
- enable low: the next cycle goes to IDLE, counters clear, timeout disarms. A partial frame is discarded with no pulses. Output data_out is retained.
- Simultaneous os_tick and start edge: the edge is taken and that tick is not counted.

Test Plan:
- OVERSAMPLE=16, 8N1: send 0xA5 -> data_valid once, data_out=0x0A5, parity_err=0, frame_err=0; busy low after the stop decision.
- 7 data bits, even parity, 2 stop bits: send 0x35 with wrong parity bit 1 -> data_valid, data_out=0x35, parity_err=1. Then send correct 0x35 -> parity_err=0.
- rx low for 4 ticks, then high -> no data_valid, busy returns to 0 after the START decision.
- Break: rx low for 20 bit times (8N1) -> exactly one break_det, no data_valid, busy until rx high. Then send 0x55 -> correct reception.
- cfg_timeout=3: send 0x12, then leave the line idle -> timeout pulses exactly 3 bit times after the stop decision, once only. Repeat with a new frame before 3 bits -> no timeout.
- 9-bit mode, odd parity: send 0x1FF -> data_out=0x1FF. Drop enable mid-frame -> no pulses; re-enable and send 0x100 -> correct.
